vga_block_plotter: RTL and testbench

- Parametrised pixel-block plotter FSM for the connect-four VGA path.
- On a start strobe it latches a base coordinate, colour and mode, then scans a BLOCK_W x BLOCK_H block in raster order. Each cycle it drives one pixel (x, y, colour, plot) to the VGA adapter write port.
- Supports three modes: solid player piece, outlined column pointer, and erase to background.
- Signals completion with a one-cycle done pulse. Supports abort.

---
 rtl/vga_block_plotter.sv | 112 +++++++++++
 tb/tb_vga_block_plotter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_block_plotter.sv
// Block plotter: scans a BLOCK_W x BLOCK_H pixel block in raster order, one pixel
// per cycle, toward the VGA adapter write port (fill, outline or erase).
module vga_block_plotter #(
   parameter int                 BLOCK_W  = 4,
   parameter int                 BLOCK_H  = 4,
   parameter int                 X_W      = 8,
   parameter int                 Y_W      = 7,
   parameter int                 COLOR_W  = 3,
   parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [X_W-1:0]     x_in,
   input  logic [Y_W-1:0]     y_in,
   input  logic [COLOR_W-1:0] color_in,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               plot,
   output logic [X_W-1:0]     x_out,
   output logic [Y_W-1:0]     y_out,
   output logic [COLOR_W-1:0] color_out
);

   localparam int CXW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
   localparam int CYW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
   localparam logic [CXW-1:0] CX_LAST = CXW'(BLOCK_W - 1);
   localparam logic [CYW-1:0] CY_LAST = CYW'(BLOCK_H - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CXW-1:0]     cx_q, cx_d;
   logic [CYW-1:0]     cy_q, cy_d;
   logic [X_W-1:0]     xb_q, xb_d;
   logic [Y_W-1:0]     yb_q, yb_d;
   logic [1:0]         mode_q, mode_d;
   logic [COLOR_W-1:0] col_q, col_d;
   logic               last_px, on_edge;

   assign last_px = (cx_q == CX_LAST) && (cy_q == CY_LAST);
   assign on_edge = (cx_q == '0) || (cx_q == CX_LAST) || (cy_q == '0) || (cy_q == CY_LAST);

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      xb_d    = xb_q;
      yb_d    = yb_q;
      mode_d  = mode_q;
      col_d   = col_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               xb_d    = x_in;
               yb_d    = y_in;
               mode_d  = mode;
               col_d   = (mode == 2'b10) ? BG_COLOR : color_in;
               cx_d    = '0;
               cy_d    = '0;
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            // Counters freeze on exit so x/y hold the last pixel outside DRAW.
            if (abort || last_px) begin
               state_d = S_DONE;
            end else if (cx_q == CX_LAST) begin
               cx_d = '0;
               cy_d = cy_q + 1'b1;
            end else begin
               cx_d = cx_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         xb_q    <= '0;
         yb_q    <= '0;
         mode_q  <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         xb_q    <= xb_d;
         yb_q    <= yb_d;
         mode_q  <= mode_d;
         col_q   <= col_d;
      end
   end

   // Outputs come from registers only; coordinates wrap modulo 2^width.
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign plot      = (state_q == S_DRAW) && ((mode_q != 2'b01) || on_edge);
   assign x_out     = xb_q + X_W'(cx_q);
   assign y_out     = yb_q + Y_W'(cy_q);
   assign color_out = col_q;

endmodule

// File: tb/tb_vga_block_plotter.sv
// Directed bench for vga_block_plotter: default 4x4 instance plus an 8x3 instance.
module tb_vga_block_plotter;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start, start8, abort;
   logic [1:0] mode;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] color_in;

   logic       busy, done, plot;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] color_out;

   logic       busy8, done8, plot8;
   logic [7:0] x_out8;
   logic [6:0] y_out8;
   logic [2:0] color_out8;

   int n_cmp = 0;
   int n_bad = 0;
   int nplot;

   always #5 clk = ~clk;

   vga_block_plotter dut (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode), .x_in(x_in),
      .y_in(y_in), .color_in(color_in), .abort(abort), .busy(busy), .done(done),
      .plot(plot), .x_out(x_out), .y_out(y_out), .color_out(color_out)
   );

   vga_block_plotter #(.BLOCK_W(8), .BLOCK_H(3)) dut8 (
      .clk(clk), .resetn(resetn), .start(start8), .mode(mode), .x_in(x_in),
      .y_in(y_in), .color_in(color_in), .abort(abort), .busy(busy8), .done(done8),
      .plot(plot8), .x_out(x_out8), .y_out(y_out8), .color_out(color_out8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; start8 = 1'b0; abort = 1'b0;
      mode = 2'b00; x_in = '0; y_in = '0; color_in = '0;
      #2;
      chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
      chk("rst_plot", plot, 0);   chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);     chk("rst_col", color_out, 0);
      chk("rst8_busy", busy8, 0); chk("rst8_plot", plot8, 0);
      #10 resetn = 1'b1;

      // Player fill at (10,20), colour 100
      mode = 2'b00; x_in = 8'd10; y_in = 7'd20; color_in = 3'b100; start = 1'b1;
      tick(); start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("fill_plot", plot, 1);
         chk("fill_x", x_out, 10 + i % 4);
         chk("fill_y", y_out, 20 + i / 4);
         chk("fill_col", color_out, 3'b100);
         chk("fill_busy", busy, 1);
         chk("fill_done", done, 0);
         tick();
      end
      chk("fill_done17", done, 1); chk("fill_plot17", plot, 0); chk("fill_busy17", busy, 1);
      chk("fill_xhold", x_out, 13); chk("fill_yhold", y_out, 23);
      tick();
      chk("fill_idle_busy", busy, 0); chk("fill_idle_done", done, 0);

      // Pointer outline at (40,0), colour 010
      mode = 2'b01; x_in = 8'd40; y_in = 7'd0; color_in = 3'b010; start = 1'b1;
      tick(); start = 1'b0; nplot = 0;
      for (int i = 0; i < 16; i++) begin
         chk("ptr_plot", plot, (i % 4 == 0 || i % 4 == 3 || i / 4 == 0 || i / 4 == 3) ? 1 : 0);
         chk("ptr_x", x_out, 40 + i % 4);
         chk("ptr_y", y_out, i / 4);
         chk("ptr_busy", busy, 1);
         if (plot) nplot++;
         tick();
      end
      chk("ptr_count", nplot, 12);
      chk("ptr_done", done, 1);
      tick();

      // Erase with coordinate wrap
      mode = 2'b10; x_in = 8'd254; y_in = 7'd126; color_in = 3'b111; start = 1'b1;
      tick(); start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("erase_plot", plot, 1);
         chk("erase_x", x_out, (254 + i % 4) % 256);
         chk("erase_y", y_out, (126 + i / 4) % 128);
         chk("erase_col", color_out, 0);
         tick();
      end
      chk("erase_done", done, 1);
      tick();

      // Start held high throughout: one block, then re-accept only from IDLE
      mode = 2'b00; x_in = 8'd0; y_in = 7'd0; color_in = 3'b011; start = 1'b1;
      tick(); nplot = 0;
      for (int i = 0; i < 16; i++) begin
         if (plot) nplot++;
         tick();
      end
      chk("held_count", nplot, 16);
      chk("held_done", done, 1); chk("held_plot", plot, 0);
      tick();
      chk("held_idle", busy, 0); chk("held_idle_plot", plot, 0);
      tick();
      chk("held_reaccept", busy, 1); chk("held_reaccept_plot", plot, 1);
      start = 1'b0;

      // Abort at the 5th pixel of this second block
      nplot = 0;
      for (int i = 0; i < 4; i++) begin
         if (plot) nplot++;
         tick();
      end
      abort = 1'b1;
      chk("abort_px5_plot", plot, 1);
      chk("abort_px5_x", x_out, 0);
      chk("abort_px5_y", y_out, 1);
      if (plot) nplot++;
      tick(); abort = 1'b0;
      chk("abort_count", nplot, 5);
      chk("abort_done", done, 1); chk("abort_plot", plot, 0);
      chk("abort_xhold", x_out, 0); chk("abort_yhold", y_out, 1);
      tick();
      chk("abort_idle", busy, 0); chk("abort_idle_done", done, 0);

      // Start with abort in IDLE is accepted; then reset at the 7th pixel
      x_in = 8'd5; y_in = 7'd6; start = 1'b1; abort = 1'b1;
      tick(); start = 1'b0; abort = 1'b0;
      chk("sa_busy", busy, 1); chk("sa_plot", plot, 1);
      for (int i = 0; i < 6; i++) tick();
      chk("rstm_px7_plot", plot, 1); chk("rstm_px7_x", x_out, 7); chk("rstm_px7_y", y_out, 7);
      resetn = 1'b0;
      #1;
      chk("rstm_plot", plot, 0); chk("rstm_busy", busy, 0);
      chk("rstm_done", done, 0); chk("rstm_x", x_out, 0);
      tick();
      #2 resetn = 1'b1;
      tick();
      chk("rstm_nodone", done, 0); chk("rstm_idle", busy, 0);
      x_in = 8'd1; y_in = 7'd2; color_in = 3'b101; start = 1'b1;
      tick(); start = 1'b0; nplot = 0;
      for (int i = 0; i < 16; i++) begin
         if (plot) nplot++;
         tick();
      end
      chk("rstm_full_count", nplot, 16);
      chk("rstm_full_done", done, 1); chk("rstm_full_x", x_out, 4); chk("rstm_full_y", y_out, 5);
      tick();

      // 8x3 instance in pointer mode
      mode = 2'b01; x_in = 8'd100; y_in = 7'd50; color_in = 3'b001; start8 = 1'b1;
      tick(); start8 = 1'b0; nplot = 0;
      for (int i = 0; i < 24; i++) begin
         chk("w8_plot", plot8, (i % 8 == 0 || i % 8 == 7 || i / 8 == 0 || i / 8 == 2) ? 1 : 0);
         chk("w8_x", x_out8, 100 + i % 8);
         chk("w8_y", y_out8, 50 + i / 8);
         chk("w8_busy", busy8, 1);
         if (plot8) nplot++;
         tick();
      end
      chk("w8_count", nplot, 18);
      chk("w8_done", done8, 1); chk("w8_plot_done", plot8, 0);
      chk("w8_other_idle", busy, 0);
      tick();
      chk("w8_idle", busy8, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
